// File: rtl/alu_unit.sv
// Registered 12-operation ALU with one-hot, lowest-bit-wins operation select.
// Define ALU_DIV_EN to build the signed divider; otherwise the div select loads zero.
module alu_unit #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [11:0]     ctrl_signal,
  input  logic [BITS-1:0] X,
  input  logic [BITS-1:0] Y,
  output logic [BITS-1:0] OpResult_HI,
  output logic [BITS-1:0] OpResult_LO
);

  localparam int SHW = (BITS > 1) ? $clog2(BITS) : 1;

  logic [SHW-1:0]         w_amt;
  logic signed [2*BITS-1:0] w_prod;
  logic [2*BITS-1:0]      w_dbl_r;
  logic [2*BITS-1:0]      w_dbl_l;
  logic [BITS-1:0]        w_hi;
  logic [BITS-1:0]        w_lo;
  logic [BITS-1:0]        r_hi;
  logic [BITS-1:0]        r_lo;

  assign w_amt   = Y[SHW-1:0];
  // Operands are sign-extended first so the product keeps all 2*BITS bits.
  assign w_prod  = $signed({{BITS{X[BITS-1]}}, X}) * $signed({{BITS{Y[BITS-1]}}, Y});
  // Rotates come from shifting a doubled copy of X and picking one half.
  assign w_dbl_r = {X, X} >> w_amt;
  assign w_dbl_l = {X, X} << w_amt;

`ifdef ALU_DIV_EN
  localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};

  logic signed [BITS-1:0] w_quot;
  logic signed [BITS-1:0] w_rem;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_quot = '0;
    w_rem  = '0;
    if (Y == '0) begin
      w_quot = '1;
      w_rem  = X;
    end else if (X == MOST_NEG && Y == '1) begin
      w_quot = X;
      w_rem  = '0;
    end else begin
      w_quot = $signed(X) / $signed(Y);
      w_rem  = $signed(X) % $signed(Y);
    end
  end
`endif

  always_comb begin
    w_hi = '0;
    w_lo = '0;
    if (ctrl_signal[0]) begin
      w_lo = X + Y;
    end else if (ctrl_signal[1]) begin
      w_lo = X - Y;
    end else if (ctrl_signal[2]) begin
      {w_hi, w_lo} = w_prod;
    end else if (ctrl_signal[3]) begin
`ifdef ALU_DIV_EN
      w_hi = w_rem;
      w_lo = w_quot;
`endif
    end else if (ctrl_signal[4]) begin
      w_lo = X >> w_amt;
    end else if (ctrl_signal[5]) begin
      w_lo = X << w_amt;
    end else if (ctrl_signal[6]) begin
      w_lo = w_dbl_r[BITS-1:0];
    end else if (ctrl_signal[7]) begin
      w_lo = w_dbl_l[2*BITS-1:BITS];
    end else if (ctrl_signal[8]) begin
      w_lo = X & Y;
    end else if (ctrl_signal[9]) begin
      w_lo = X | Y;
    end else if (ctrl_signal[10]) begin
      w_lo = '0 - X;
    end else if (ctrl_signal[11]) begin
      w_lo = ~X;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_hi <= w_hi;
      r_lo <= w_lo;
    end
  end

  assign OpResult_HI = r_hi;
  assign OpResult_LO = r_lo;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors pin the reference model,
// then random ops run against it every cycle, with occasional async reset pulses.
module tb_alu_unit;

  logic        clk;
  logic        clr;
  logic [11:0] ctrl;
  logic [31:0] xv;
  logic [31:0] yv;
  logic [31:0] hi;
  logic [31:0] lo;

  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;
  logic [63:0] exp_r;

  alu_unit #(.BITS(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .ctrl_signal (ctrl),
    .X           (xv),
    .Y           (yv),
    .OpResult_HI (hi),
    .OpResult_LO (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Reference model: returns {HI, LO} from the operation rules using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y);
    int          idx = -1;
    longint      sx  = longint'($signed(x));
    longint      sy  = longint'($signed(y));
    int          amt = int'(y[4:0]);
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    for (int i = 0; i < 12; i++)
      if (c[i] && idx < 0) idx = i;
    case (idx)
      0: mlo = 32'(sx + sy);
      1: mlo = 32'(sx - sy);
      2: {mhi, mlo} = 64'(sx * sy);
      3: begin
`ifdef ALU_DIV_EN
        if (sy == 0) begin
          mlo = 32'hFFFF_FFFF;
          mhi = x;
        end else begin
          mlo = 32'(sx / sy);
          mhi = 32'(sx % sy);
        end
`endif
      end
      4: mlo = x >> amt;
      5: mlo = x << amt;
      6: for (int k = 0; k < 32; k++) mlo[k] = x[(k + amt) % 32];
      7: for (int k = 0; k < 32; k++) mlo[(k + amt) % 32] = x[k];
      8: mlo = x & y;
      9: mlo = x | y;
      10: mlo = 32'(-sx);
      11: mlo = ~x;
      default: ;
    endcase
    return {mhi, mlo};
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) exp_r <= '0;
    else      exp_r <= model(ctrl, xv, yv);
  end

  always @(negedge clk) begin
    if (chk_on) check("cycle", {hi, lo}, exp_r);
  end

  task automatic run_op(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    @(negedge clk);
    ctrl = c;
    xv   = x;
    yv   = y;
    check({nm, "_model"}, model(c, x, y), {eh, el});
    @(posedge clk);
    #1;
    check({nm, "_dut"}, {hi, lo}, {eh, el});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      5: return 32'(-$urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    ctrl = '0;
    xv   = '0;
    yv   = '0;
    clr  = 1'b1;
    #2 clr = 1'b0;
    #1 check("reset_state", {hi, lo}, 64'h0);
    @(negedge clk);
    check("reset_after_edge", {hi, lo}, 64'h0);
    clr = 1'b1;

    run_op(12'h001, 32'd15, 32'd5, 32'h0, 32'd20, "add");
    run_op(12'h002, 32'd15, 32'd5, 32'h0, 32'd10, "sub");
    run_op(12'h002, -32'sd15, -32'sd5, 32'h0, 32'hFFFF_FFF6, "sub_neg");
    run_op(12'h004, -32'sd15, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFB5, "mul_neg");
    run_op(12'h004, -32'sd15, -32'sd5, 32'h0, 32'd75, "mul_pos");
    run_op(12'h004, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mul_min");
`ifdef ALU_DIV_EN
    run_op(12'h008, -32'sd15, 32'd5, 32'h0, 32'hFFFF_FFFD, "div");
    run_op(12'h008, 32'd15, 32'd0, 32'd15, 32'hFFFF_FFFF, "div_zero");
    run_op(12'h008, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");
    run_op(12'h008, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_rem");
`else
    div_hi = 32'h0;
    div_lo = 32'h0;
    run_op(12'h008, -32'sd15, 32'd5, div_hi, div_lo, "div_off");
    run_op(12'h008, 32'd15, 32'd0, div_hi, div_lo, "div_off_zero");
`endif
    run_op(12'h010, 32'd16, 32'd2, 32'h0, 32'd4, "shr");
    run_op(12'h020, 32'd16, 32'd2, 32'h0, 32'd64, "shl");
    run_op(12'h040, 32'd16, 32'd2, 32'h0, 32'd4, "ror");
    run_op(12'h080, 32'd16, 32'd2, 32'h0, 32'd64, "rol");
    run_op(12'h040, 32'd1, 32'd1, 32'h0, 32'h8000_0000, "ror_wrap");
    run_op(12'h080, 32'h1234_5678, 32'd32, 32'h0, 32'h1234_5678, "rol_amt0");
    run_op(12'h010, 32'h8000_0000, 32'hFFFF_FFE1, 32'h0, 32'h4000_0000, "shr_upper_ign");
    run_op(12'h100, 32'd15, 32'd0, 32'h0, 32'd0, "and");
    run_op(12'h200, 32'd15, 32'd0, 32'h0, 32'd15, "or");
    run_op(12'h400, 32'd15, 32'd0, 32'h0, 32'hFFFF_FFF1, "neg");
    run_op(12'h400, 32'h8000_0000, 32'd9, 32'h0, 32'h8000_0000, "neg_min");
    run_op(12'h800, 32'd15, 32'd0, 32'h0, 32'hFFFF_FFF0, "not");
    run_op(12'h000, 32'd15, 32'd5, 32'h0, 32'h0, "none");
    run_op(12'h006, 32'd15, 32'd5, 32'h0, 32'd10, "priority");
    run_op(12'hC10, 32'd16, 32'd2, 32'h0, 32'd4, "priority_hi");

    // Asynchronous reset between edges, then release and reload.
    run_op(12'h001, 32'd15, 32'd5, 32'h0, 32'd20, "pre_reset");
    #1 clr = 1'b0;
    #1 check("reset_async", {hi, lo}, 64'h0);
    #1 clr = 1'b1;
    #1 check("reset_release_hold", {hi, lo}, 64'h0);
    @(posedge clk);
    #1 check("reset_reload", {hi, lo}, {32'h0, 32'd20});

    chk_on = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      int k;
      @(negedge clk);
      k = $urandom_range(0, 13);
      if (k == 12)      ctrl = '0;
      else if (k == 13) ctrl = 12'($urandom);
      else              ctrl = (12'b1 << k) | (($urandom_range(0, 1) == 1) ? (12'($urandom) << (k + 1)) : 12'h0);
      xv = pick_operand();
      yv = pick_operand();
      if ($urandom_range(0, 49) == 0) begin
        #2 clr = 1'b0;
        #1 check("rand_reset", {hi, lo}, 64'h0);
        #1 clr = 1'b1;
      end
    end
    @(negedge clk);
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter: BITS, default 32, operand/result width.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 clr  input  1  asynchronous active-low reset.
REQ-004 ctrl_signal  input  12  one-hot operation select (bit map in REQ-010).
REQ-005 X  input  BITS  operand A, two's-complement signed.
REQ-006 Y  input  BITS  operand B, two's-complement signed; shift amount for shift/rotate ops.
REQ-007 OpResult_HI  output  BITS  upper result word, registered.
REQ-008 OpResult_LO  output  BITS  lower result word, registered.

Function
REQ-009 Outputs SHALL be registered: the result of the X, Y and ctrl_signal sampled at rising edge N SHALL be visible after edge N; latency 1 cycle, throughput 1 op per cycle, no handshake.
REQ-010 ctrl_signal bit map SHALL be:
- bit0 add
- bit1 sub
- bit2 mul
- bit3 div
- bit4 shr
- bit5 shl
- bit6 ror
- bit7 rol
- bit8 and
- bit9 or
- bit10 neg
- bit11 not
REQ-011 If more than one bit is set, the lowest-index set bit SHALL win; if no bit is set, both outputs SHALL load 0.
REQ-012 add: LO = X+Y modulo 2^BITS, no carry/overflow flag; HI = 0.
REQ-013 sub: LO = X-Y modulo 2^BITS; HI = 0.
REQ-014 mul: {HI,LO} = full 2*BITS-bit signed product X*Y; no truncation.
REQ-015 div: LO = signed quotient X/Y truncated toward zero; HI = remainder with the sign of X; X = Q*Y + R.
REQ-016 div by zero: LO = all ones, HI = X.
REQ-017 div overflow (X = most negative, Y = -1): LO = X, HI = 0.
REQ-018 Shift/rotate amount: Y[4:0] for BITS=32 (generally Y[$clog2(BITS)-1:0]); upper Y bits ignored.
REQ-019 shr: logical right shift (zero fill).
REQ-020 shl: left shift (zero fill).
REQ-021 ror/rol: rotate right/left; amount 0 returns X.
REQ-022 For shr, shl, ror and rol, HI = 0.
REQ-023 and: LO = X&Y; or: LO = X|Y; HI = 0.
REQ-024 neg: LO = -X (two's complement; most negative value maps to itself); not: LO = ~X; Y ignored; HI = 0.
REQ-025 All arithmetic SHALL be combinational within one clock period; no multi-cycle paths.

Reset
REQ-026 While clr = 0, OpResult_HI and OpResult_LO SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight result; the first edge after clr rises SHALL load the current inputs normally.

Configuration
REQ-028 Macro ALU_DIV_EN:
- Defined: the divider is compiled in and bit3 behaves per REQ-015..REQ-017.
- Undefined: no divider logic is built and bit3 loads HI = 0, LO = 0.

Verification
REQ-029 add/sub: X=15, Y=5 -> add LO=20, HI=0; sub LO=10, HI=0; with X=-15, Y=-5 -> sub LO=-10 (0xFFFFFFF6).
REQ-030 mul: X=-15, Y=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFB5 (-75); with X=-15, Y=-5 -> HI=0, LO=75.
REQ-031 div (ALU_DIV_EN): X=-15, Y=5 -> LO=-3, HI=0; X=15, Y=0 -> LO=0xFFFFFFFF, HI=15; without ALU_DIV_EN -> both 0.
REQ-032 shift/rotate with X=16, Y=2: shr LO=4, shl LO=64, ror LO=4, rol LO=64; X=1, Y=1, ror -> LO=0x80000000.
REQ-033 logic with X=15, Y=0: and LO=0, or LO=15, neg LO=0xFFFFFFF1, not LO=0xFFFFFFF0; ctrl_signal=0 -> both 0.
REQ-034 Reset: with valid results held, drive clr low between clock edges -> outputs 0 before the next edge; release -> result appears one edge later.
